// File: rtl/rat_flag_intr_if.sv
// Bus between the ALU/control unit and the RAT flag and interrupt unit.
// The flag unit is the slave; the control unit / ALU side is the master.
interface rat_flag_intr_if;
  logic       alu_c;
  logic       alu_z;
  logic       flg_c_ld;
  logic       flg_z_ld;
  logic       flg_c_set;
  logic       flg_c_clr;
  logic       flg_restore;
  logic       i_set;
  logic       i_clr;
  logic [2:0] br_cond;
  logic       intr;
  logic       int_ack;
  logic       c_flag;
  logic       z_flag;
  logic       i_flag;
  logic       br_taken;
  logic       int_req;

  modport master (
    output alu_c, alu_z, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr, flg_restore,
           i_set, i_clr, br_cond, intr, int_ack,
    input  c_flag, z_flag, i_flag, br_taken, int_req
  );

  modport slave (
    input  alu_c, alu_z, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr, flg_restore,
           i_set, i_clr, br_cond, intr, int_ack,
    output c_flag, z_flag, i_flag, br_taken, int_req
  );
endinterface

// File: rtl/rat_flag_intr_unit.sv
// RAT status unit: C/Z flags with interrupt shadows, interrupt enable, branch
// condition decode and a synchronised, edge-detected interrupt REQ/ACK handshake.
module rat_flag_intr_unit #(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic            clk,
  input  logic            rst_n,
  rat_flag_intr_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                 state_reg;
  logic                   c_reg, z_reg, i_reg;
  logic                   shad_c_reg, shad_z_reg;
  logic                   int_req_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync_prev_reg;
  logic                   c_next, z_next, i_next;
  logic                   rise;
  logic                   br_raw;

  // Synchroniser chain: stage 0 samples the raw line, each later stage the one before.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = bus.intr;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign rise = sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;

  always_comb begin
    c_next = c_reg;
    if (bus.flg_restore)    c_next = shad_c_reg;
    else if (bus.flg_c_set) c_next = 1'b1;
    else if (bus.flg_c_clr) c_next = 1'b0;
    else if (bus.flg_c_ld)  c_next = bus.alu_c;

    z_next = z_reg;
    if (bus.flg_restore)   z_next = shad_z_reg;
    else if (bus.flg_z_ld) z_next = bus.alu_z;

    i_next = i_reg;
    if (bus.int_ack)    i_next = 1'b0;
    else if (bus.i_clr) i_next = 1'b0;
    else if (bus.i_set) i_next = 1'b1;
  end

  always_comb begin
    br_raw = 1'b0;
    case (bus.br_cond)
      3'b001:  br_raw = 1'b1;
      3'b010:  br_raw = z_reg;
      3'b011:  br_raw = ~z_reg;
      3'b100:  br_raw = c_reg;
      3'b101:  br_raw = ~c_reg;
      default: br_raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      c_reg         <= 1'b0;
      z_reg         <= 1'b0;
      i_reg         <= 1'b0;
      shad_c_reg    <= 1'b0;
      shad_z_reg    <= 1'b0;
      int_req_reg   <= 1'b0;
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
    end else begin
      c_reg         <= c_next;
      z_reg         <= z_next;
      i_reg         <= i_next;
      sync_reg      <= sync_next;
      sync_prev_reg <= sync_reg[SYNC_STAGES-1];
      case (state_reg)
        IDLE: begin
          // A rise while interrupts are disabled is dropped, never queued.
          if (rise && i_reg) begin
            state_reg   <= PEND;
            int_req_reg <= 1'b1;
          end
        end
        PEND: begin
          if (bus.int_ack) begin
            state_reg   <= SERVICE;
            int_req_reg <= 1'b0;
            // Capture next-state values so a flag load in the ack cycle survives.
            shad_c_reg  <= c_next;
            shad_z_reg  <= z_next;
          end else if (bus.i_clr) begin
            state_reg   <= IDLE;
            int_req_reg <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.flg_restore) state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          int_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.c_flag   = c_reg;
  assign bus.z_flag   = z_reg;
  assign bus.i_flag   = i_reg;
  assign bus.int_req  = int_req_reg;
  // Held low while in reset even for the unconditional-branch encoding.
  assign bus.br_taken = br_raw & rst_n;

endmodule

// File: tb/tb_rat_flag_intr_unit.sv
// Directed bench for rat_flag_intr_unit: flags, branch decode, interrupt handshake,
// collisions and asynchronous reset, with hand-computed expectations.
module tb_rat_flag_intr_unit;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  rat_flag_intr_if bus ();

  rat_flag_intr_unit #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    bus.alu_c       = 1'b0;
    bus.alu_z       = 1'b0;
    bus.flg_c_ld    = 1'b0;
    bus.flg_z_ld    = 1'b0;
    bus.flg_c_set   = 1'b0;
    bus.flg_c_clr   = 1'b0;
    bus.flg_restore = 1'b0;
    bus.i_set       = 1'b0;
    bus.i_clr       = 1'b0;
    bus.int_ack     = 1'b0;
  endtask

  // Low for three cycles, then a rise; request (if enabled) is visible afterwards.
  task automatic fresh_rise();
    bus.intr = 1'b0;
    repeat (3) step();
    bus.intr = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    rst_n       = 1'b0;
    clr_ctl();
    bus.intr    = 1'b0;
    bus.br_cond = 3'b001;
    #1;
    chk("rst_c", bus.c_flag, 1'b0);
    chk("rst_z", bus.z_flag, 1'b0);
    chk("rst_i", bus.i_flag, 1'b0);
    chk("rst_req", bus.int_req, 1'b0);
    chk("rst_br001", bus.br_taken, 1'b0);
    bus.br_cond = 3'b000;
    repeat (2) step();
    #2 rst_n = 1'b1;
    step();

    // Flag loads and branch decode
    bus.alu_c = 1'b1; bus.alu_z = 1'b0; bus.flg_c_ld = 1'b1; bus.flg_z_ld = 1'b1;
    step(); clr_ctl();
    chk("ld_c", bus.c_flag, 1'b1);
    chk("ld_z", bus.z_flag, 1'b0);
    bus.br_cond = 3'b100; #1 chk("br_cs", bus.br_taken, 1'b1);
    bus.br_cond = 3'b010; #1 chk("br_eq", bus.br_taken, 1'b0);
    bus.br_cond = 3'b011; #1 chk("br_ne", bus.br_taken, 1'b1);
    bus.br_cond = 3'b101; #1 chk("br_cc", bus.br_taken, 1'b0);
    bus.br_cond = 3'b001; #1 chk("br_n", bus.br_taken, 1'b1);
    bus.br_cond = 3'b110; #1 chk("br_110", bus.br_taken, 1'b0);
    bus.alu_z = 1'b1; bus.flg_z_ld = 1'b1;
    step(); clr_ctl();
    chk("ld_z1", bus.z_flag, 1'b1);
    chk("hold_c", bus.c_flag, 1'b1);
    bus.br_cond = 3'b010; #1 chk("br_eq1", bus.br_taken, 1'b1);
    bus.br_cond = 3'b111; #1 chk("br_111", bus.br_taken, 1'b0);
    bus.br_cond = 3'b000;
    bus.flg_z_ld = 1'b1; bus.alu_z = 1'b0;
    step(); clr_ctl();
    chk("ld_z0", bus.z_flag, 1'b0);

    // Interrupt request latency and hold
    bus.i_set = 1'b1;
    step(); clr_ctl();
    chk("sei", bus.i_flag, 1'b1);
    bus.intr = 1'b1;
    step(); chk("lat_n", bus.int_req, 1'b0);
    step(); chk("lat_n1", bus.int_req, 1'b0);
    step(); chk("lat_n2", bus.int_req, 1'b1);
    repeat (5) step();
    chk("req_hold", bus.int_req, 1'b1);
    bus.int_ack = 1'b1;
    step(); clr_ctl();
    chk("ack_req", bus.int_req, 1'b0);
    chk("ack_i", bus.i_flag, 1'b0);

    // Service: modify flags, ignored rise, then restore
    bus.flg_c_clr = 1'b1; bus.alu_z = 1'b1; bus.flg_z_ld = 1'b1;
    step(); clr_ctl();
    chk("svc_c", bus.c_flag, 1'b0);
    chk("svc_z", bus.z_flag, 1'b1);
    fresh_rise();
    chk("svc_norise", bus.int_req, 1'b0);
    bus.flg_restore = 1'b1; bus.i_set = 1'b1;
    step(); clr_ctl();
    chk("rest_c", bus.c_flag, 1'b1);
    chk("rest_z", bus.z_flag, 1'b0);
    chk("rest_i", bus.i_flag, 1'b1);
    fresh_rise();
    chk("idle_again", bus.int_req, 1'b1);
    bus.i_clr = 1'b1;
    step(); clr_ctl();
    chk("cancel_req", bus.int_req, 1'b0);
    chk("cancel_i", bus.i_flag, 1'b0);
    repeat (3) step();
    chk("cancel_stay", bus.int_req, 1'b0);

    // Rise with I=0 is discarded, even after a later SEI
    fresh_rise();
    step();
    chk("dis_req", bus.int_req, 1'b0);
    bus.i_set = 1'b1;
    step(); clr_ctl();
    repeat (4) step();
    chk("dis_after_sei", bus.int_req, 1'b0);
    chk("dis_i", bus.i_flag, 1'b1);

    // Collisions
    bus.flg_c_clr = 1'b1;
    step(); clr_ctl();
    chk("clc", bus.c_flag, 1'b0);
    bus.flg_c_set = 1'b1; bus.flg_c_clr = 1'b1;
    step(); clr_ctl();
    chk("set_clr", bus.c_flag, 1'b1);
    bus.flg_c_clr = 1'b1;
    step(); clr_ctl();
    fresh_rise();
    chk("col_req", bus.int_req, 1'b1);
    bus.int_ack = 1'b1; bus.flg_c_ld = 1'b1; bus.alu_c = 1'b1; bus.i_clr = 1'b1;
    step(); clr_ctl();
    chk("col_c", bus.c_flag, 1'b1);
    chk("col_req0", bus.int_req, 1'b0);
    chk("col_i", bus.i_flag, 1'b0);
    bus.flg_c_clr = 1'b1;
    step(); clr_ctl();
    chk("col_c0", bus.c_flag, 1'b0);
    bus.flg_restore = 1'b1;
    step(); clr_ctl();
    chk("shad_c", bus.c_flag, 1'b1);
    bus.i_set = 1'b1;
    step(); clr_ctl();
    bus.int_ack = 1'b1;
    step(); clr_ctl();
    chk("ack_idle_i", bus.i_flag, 1'b0);
    chk("ack_idle_req", bus.int_req, 1'b0);

    // Asynchronous reset mid-PEND
    bus.alu_z = 1'b1; bus.flg_z_ld = 1'b1; bus.i_set = 1'b1;
    step(); clr_ctl();
    fresh_rise();
    chk("pre_rst_req", bus.int_req, 1'b1);
    chk("pre_rst_z", bus.z_flag, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", bus.int_req, 1'b0);
    chk("arst_c", bus.c_flag, 1'b0);
    chk("arst_z", bus.z_flag, 1'b0);
    chk("arst_i", bus.i_flag, 1'b0);
    step();
    #3 rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_req", bus.int_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
